// File: rtl/fp_mul_pkg.sv
// Shared bfloat16 field widths, status codes and payload type for the fp_mul block.
package fp_mul_pkg;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 7;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned DATA_W = 1 + EXP_W + FRAC_W;
    localparam int unsigned ERR_W  = 2;

    localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;
    localparam logic [ERR_W-1:0] ERR_OVF  = 2'b01;
    localparam logic [ERR_W-1:0] ERR_UNF  = 2'b10;
    localparam logic [ERR_W-1:0] ERR_INV  = 2'b11;

    localparam logic [DATA_W-1:0] QNAN = 16'h7FC0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } bf16_t;
endpackage

// File: rtl/fp_mul_if.sv
// Operand/result bundle for fp_mul; no handshake, one operand pair per clock.
interface fp_mul_if import fp_mul_pkg::*; #(
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter int unsigned ERROR_WIDTH = ERR_W
);
    logic [DATA_WIDTH-1:0]  in1;
    logic [DATA_WIDTH-1:0]  in2;
    logic [DATA_WIDTH-1:0]  out;
    logic [ERROR_WIDTH-1:0] error;

    modport master (output in1, output in2, input  out, input  error);
    modport slave  (input  in1, input  in2, output out, output error);
endinterface

// File: rtl/fp_mul_core.sv
// Combinational bfloat16 multiply: classify, multiply, normalize, round, pack.
// Rounding mode: truncation by default, round-to-nearest-even with FP_MUL_RNE_EN.
module fp_mul_core import fp_mul_pkg::*; (
    input  bf16_t            i_a,
    input  bf16_t            i_b,
    output bf16_t            o_prod_c,
    output logic [ERR_W-1:0] o_err_c
);
    localparam int unsigned EXP_IW = 10;

    logic                     w_s;
    logic                     w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic                     w_inv;
    logic [FRAC_W:0]          w_ma, w_mb;
    logic [15:0]              w_prod;
    logic signed [EXP_IW-1:0] w_exp_raw, w_exp_n, w_exp_fin;
    logic [FRAC_W-1:0]        w_frac;
    logic                     w_rnd;
    logic [FRAC_W:0]          w_frac_rnd;

    // Subnormals (exp=0) fold into the zero class.
    assign w_s      = i_a.sign ^ i_b.sign;
    assign w_nan_a  = (i_a.exp == '1) && (i_a.frac != '0);
    assign w_nan_b  = (i_b.exp == '1) && (i_b.frac != '0);
    assign w_inf_a  = (i_a.exp == '1) && (i_a.frac == '0);
    assign w_inf_b  = (i_b.exp == '1) && (i_b.frac == '0);
    assign w_zero_a = (i_a.exp == '0);
    assign w_zero_b = (i_b.exp == '0);
    assign w_inv    = w_nan_a | w_nan_b | (w_zero_a & w_inf_b) | (w_inf_a & w_zero_b);

    assign w_ma      = {1'b1, i_a.frac};
    assign w_mb      = {1'b1, i_b.frac};
    assign w_prod    = 16'(w_ma) * 16'(w_mb);
    assign w_exp_raw = EXP_IW'(i_a.exp) + EXP_IW'(i_b.exp) - EXP_IW'(BIAS);

    always_comb begin
        w_exp_n = w_exp_raw;
        w_frac  = w_prod[13:7];
        if (w_prod[15]) begin
            w_exp_n = w_exp_raw + EXP_IW'(1);
            w_frac  = w_prod[14:8];
        end
    end

`ifdef FP_MUL_RNE_EN
    logic w_guard, w_sticky;
    assign w_guard  = w_prod[15] ? w_prod[7] : w_prod[6];
    assign w_sticky = w_prod[15] ? (|w_prod[6:0]) : (|w_prod[5:0]);
    assign w_rnd    = w_guard & (w_sticky | w_frac[0]);
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^w_prod[6:0];
    assign w_rnd         = 1'b0;
`endif

    // A carry out leaves the low fraction bits at zero, so only the exponent needs bumping.
    assign w_frac_rnd = {1'b0, w_frac} + (FRAC_W+1)'(w_rnd);
    assign w_exp_fin  = w_exp_n + EXP_IW'(w_frac_rnd[FRAC_W]);

    always_comb begin
        o_prod_c = '{sign: w_s, exp: w_exp_fin[EXP_W-1:0], frac: w_frac_rnd[FRAC_W-1:0]};
        o_err_c  = ERR_NONE;
        if (w_inv) begin
            o_prod_c = bf16_t'(QNAN);
            o_err_c  = ERR_INV;
        end else if (w_inf_a | w_inf_b) begin
            o_prod_c = '{sign: w_s, exp: '1, frac: '0};
        end else if (w_zero_a | w_zero_b) begin
            o_prod_c = '{sign: w_s, exp: '0, frac: '0};
        end else if (w_exp_fin >= EXP_IW'((1 << EXP_W) - 1)) begin
            o_prod_c = '{sign: w_s, exp: '1, frac: '0};
            o_err_c  = ERR_OVF;
        end else if (w_exp_fin <= EXP_IW'(0)) begin
            o_prod_c = '{sign: w_s, exp: '0, frac: '0};
            o_err_c  = ERR_UNF;
        end
    end
endmodule

// File: rtl/fp_mul.sv
// Registered bfloat16 multiplier: one result per clock, one cycle latency.
// Rounding mode selected by FP_MUL_RNE_EN inside fp_mul_core.
module fp_mul import fp_mul_pkg::*; #(
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter int unsigned ERROR_WIDTH = ERR_W
) (
    input  logic     clk,
    input  logic     rst,
    fp_mul_if.slave  bus
);
    bf16_t                  w_prod;
    logic [ERR_W-1:0]       w_err;
    logic [DATA_WIDTH-1:0]  r_out;
    logic [ERROR_WIDTH-1:0] r_err;

    fp_mul_core u_core (
        .i_a      (bf16_t'(bus.in1)),
        .i_b      (bf16_t'(bus.in2)),
        .o_prod_c (w_prod),
        .o_err_c  (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_err <= ERROR_WIDTH'(ERR_NONE);
        end else begin
            r_out <= DATA_WIDTH'(w_prod);
            r_err <= ERROR_WIDTH'(w_err);
        end
    end

    assign bus.out   = r_out;
    assign bus.error = r_err;
endmodule

// File: tb/tb_fp_mul.sv
// Scoreboard bench for fp_mul: real-valued reference model, random + directed operands.
module tb_fp_mul;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [17:0] res;
    } exp_t;

    logic clk;
    logic rst;
    logic drv_vld;
    logic smp_vld;
    logic end_chk;
    logic end_done;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    fp_mul_if bus ();

    fp_mul dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact real product, renormalised and rounded by value.
    function automatic logic [17:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int  ea, eb, fa, fb, k, q, be;
        bit  s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        real x, y, r;
        ea = int'(a[14:7]); fa = int'(a[6:0]);
        eb = int'(b[14:7]); fb = int'(b[6:0]);
        s  = a[15] ^ b[15];
        nan_a = (ea == 255) && (fa != 0);  nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);  inf_b = (eb == 255) && (fb == 0);
        zero_a = (ea == 0);                zero_b = (eb == 0);
        if (nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b)) return {2'b11, 16'h7FC0};
        if (inf_a || inf_b) return {2'b00, s, 8'hFF, 7'h00};
        if (zero_a || zero_b) return {2'b00, s, 15'h0000};
        x = ((128.0 + fa) / 128.0) * ((128.0 + fb) / 128.0);
        k = ea + eb - 254;
        while (x >= 2.0) begin
            x = x / 2.0;
            k = k + 1;
        end
        y = x * 128.0;
        q = int'($floor(y));
        r = y - q;
`ifdef FP_MUL_RNE_EN
        if ((r > 0.5) || ((r == 0.5) && (q % 2 == 1))) q = q + 1;
`else
        if (r < 0.0) q = q - 1;
`endif
        if (q == 256) begin
            q = 128;
            k = k + 1;
        end
        be = k + 127;
        if (be >= 255) return {2'b01, s, 8'hFF, 7'h00};
        if (be <= 0) return {2'b10, s, 15'h0000};
        return {2'b00, s, 8'(be), 7'(q - 128)};
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v[14:7] = 8'h00;
            1: v[14:7] = 8'hFF;
            2: v[14:7] = 8'($urandom_range(60, 68));
            3: v[14:7] = 8'($urandom_range(186, 194));
            4: v[6:0]  = 7'h7F;
            5: v[6:0]  = 7'h00;
            default: ;
        endcase
        return v;
    endfunction

    task automatic apply(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in1 = a;
        bus.in2 = b;
        drv_vld = 1'b1;
        e.a = a;
        e.b = b;
        e.res = ref_mul(a, b);
        exp_q.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) smp_vld <= 1'b0;
        else     smp_vld <= drv_vld;
    end

    // Monitor: reset state while rst is high, otherwise pop one expectation per sampled vector.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            n_vec = n_vec + 1;
            if (bus.out !== 16'h0000 || bus.error !== 2'b00) begin
                n_err = n_err + 1;
                $display("FAIL reset_state: out=%h err=%b, required out=0000 err=00", bus.out, bus.error);
            end
        end else if (smp_vld) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL scoreboard_empty: out=%h err=%b with no expectation queued", bus.out, bus.error);
            end else begin
                e = exp_q.pop_front();
                if ({bus.error, bus.out} !== e.res) begin
                    n_err = n_err + 1;
                    $display("FAIL product %h*%h: out=%h err=%b, required out=%h err=%b",
                             e.a, e.b, bus.out, bus.error, e.res[15:0], e.res[17:16]);
                end
            end
        end
        if (end_chk && !end_done) begin
            end_done = 1'b1;
            n_vec = n_vec + 1;
            if (exp_q.size() != 0) begin
                n_err = n_err + 1;
                $display("FAIL scoreboard_leftover: %0d results never appeared, required 0", exp_q.size());
            end
        end
    end

    initial begin
        logic [15:0] dir_a [14];
        logic [15:0] dir_b [14];
        exp_t        e;
        dir_a = '{16'h3F80, 16'hC000, 16'h3FC0, 16'h7F00, 16'h0080, 16'h8080, 16'h0000,
                  16'h7FC1, 16'hFF80, 16'h0001, 16'h3F81, 16'h3FFF, 16'h4000, 16'h7F80};
        dir_b = '{16'h4000, 16'h4040, 16'h3FC0, 16'h7F00, 16'h0080, 16'h0080, 16'h7F80,
                  16'h3F80, 16'h4000, 16'h4000, 16'h3F81, 16'h3F81, 16'h3FFF, 16'h8000};
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        drv_vld  = 1'b0;
        end_chk  = 1'b0;
        end_done = 1'b0;
        bus.in1  = 16'h0000;
        bus.in2  = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) apply(dir_a[i], dir_b[i]);
        for (int i = 0; i < 1500; i++) apply(rand_bf(), rand_bf());

        // Drain, then hit reset between edges with a live operand pair on the bus.
        @(posedge clk);
        #1 drv_vld = 1'b0;
        @(posedge clk);
        #1;
        bus.in1 = 16'h3F80;
        bus.in2 = 16'h4000;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drv_vld = 1'b1;
        e.a = 16'h3F80;
        e.b = 16'h4000;
        e.res = ref_mul(16'h3F80, 16'h4000);
        exp_q.push_back(e);

        for (int i = 0; i < 300; i++) apply(rand_bf(), rand_bf());

        @(posedge clk);
        #1 drv_vld = 1'b0;
        @(posedge clk);
        #1 end_chk = 1'b1;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
